// File: rtl/stonyman_adc_capture_if.sv
// Signal bundle between the Stonyman capture block and its controller, ADC and frame buffer.
// master: controller/ADC/frame-buffer side; slave: the capture block.
interface stonyman_adc_capture_if;
  logic        frame_capture_start;
  logic        adc_capture_start;
  logic        adc_capture_done;
  logic        adc_cs_n;
  logic        adc_sclk;
  logic        adc_sdo;
  logic [11:0] pixel_data;
  logic [13:0] pixel_addr;
  logic        pixel_valid;
  logic        busy;
  logic        overflow;

  modport master (
    output frame_capture_start, adc_capture_start, adc_sdo,
    input  adc_capture_done, adc_cs_n, adc_sclk, pixel_data, pixel_addr,
           pixel_valid, busy, overflow
  );

  modport slave (
    input  frame_capture_start, adc_capture_start, adc_sdo,
    output adc_capture_done, adc_cs_n, adc_sclk, pixel_data, pixel_addr,
           pixel_valid, busy, overflow
  );
endinterface

// File: rtl/stonyman_adc_capture.sv
// Runs one 16-slot serial ADC conversion per capture request and writes the 12-bit
// sample to the frame buffer at an auto-incrementing address; sticky overflow past NUM_PIXELS.
module stonyman_adc_capture #(
  parameter int SCLK_DIV     = 2,
  parameter int QUIET_CYCLES = 4,
  parameter int NUM_PIXELS   = 12544
) (
  input  logic                   clk,
  input  logic                   reset,
  stonyman_adc_capture_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, CONV, DONE, QUIET} state_t;

  localparam logic [3:0]  DIV_LAST   = 4'(SCLK_DIV - 1);
  localparam logic [3:0]  QUIET_LAST = 4'(QUIET_CYCLES - 1);
  localparam logic [13:0] ADDR_LIMIT = 14'(NUM_PIXELS);

  state_t      state, state_next;
  logic [3:0]  div_cnt;
  logic [3:0]  bit_cnt;
  logic        sclk_high;
  logic [3:0]  quiet_cnt;
  logic [11:0] shift_reg;
  logic [11:0] pixel_data;
  logic [13:0] pixel_addr;
  logic        overflow;

  logic phase_end, sample_now, conv_end, quiet_end, at_limit;
  logic cs_n, sclk, done, valid, busy;

  assign phase_end  = (div_cnt == DIV_LAST);
  assign sample_now = (state == CONV) && !sclk_high && phase_end;
  assign conv_end   = (state == CONV) && sclk_high && phase_end && (bit_cnt == 4'd15);
  assign quiet_end  = (quiet_cnt == QUIET_LAST);
  assign at_limit   = (pixel_addr == ADDR_LIMIT);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    cs_n       = 1'b1;
    sclk       = 1'b1;
    done       = 1'b0;
    valid      = 1'b0;
    busy       = 1'b1;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (bus.adc_capture_start) state_next = CONV;
      end
      CONV: begin
        cs_n = 1'b0;
        sclk = sclk_high;
        if (conv_end) state_next = DONE;
      end
      DONE: begin
        done       = 1'b1;
        valid      = !at_limit;
        state_next = QUIET;
      end
      QUIET: begin
        if (quiet_end) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Each slot is a low half then a high half of SCLK_DIV cycles; the slot counter advances at the end of the high half.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_cnt   <= '0;
      bit_cnt   <= '0;
      sclk_high <= 1'b0;
      quiet_cnt <= '0;
    end else begin
      if (state == CONV) begin
        if (phase_end) begin
          div_cnt   <= '0;
          sclk_high <= !sclk_high;
          if (sclk_high) bit_cnt <= bit_cnt + 4'd1;
        end else begin
          div_cnt <= div_cnt + 4'd1;
        end
      end else begin
        div_cnt   <= '0;
        bit_cnt   <= '0;
        sclk_high <= 1'b0;
      end
      if (state == QUIET) quiet_cnt <= quiet_cnt + 4'd1;
      else                quiet_cnt <= '0;
    end
  end

  // Only 12 bits are kept: the four leading ADC zeros shift out of the top before the word completes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shift_reg  <= '0;
      pixel_data <= '0;
    end else begin
      if (sample_now) shift_reg <= {shift_reg[10:0], bus.adc_sdo};
      if (conv_end)   pixel_data <= shift_reg;
    end
  end

  // A frame restart wins over the post-write increment; the write itself still uses the old address.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pixel_addr <= '0;
      overflow   <= 1'b0;
    end else if (bus.frame_capture_start) begin
      pixel_addr <= '0;
      overflow   <= 1'b0;
    end else if (state == DONE) begin
      if (at_limit) overflow   <= 1'b1;
      else          pixel_addr <= pixel_addr + 14'd1;
    end
  end

  assign bus.adc_cs_n         = cs_n;
  assign bus.adc_sclk         = sclk;
  assign bus.adc_capture_done = done;
  assign bus.pixel_valid      = valid;
  assign bus.busy             = busy;
  assign bus.pixel_data       = pixel_data;
  assign bus.pixel_addr       = pixel_addr;
  assign bus.overflow         = overflow;

endmodule

// File: tb/tb_stonyman_adc_capture.sv
// Bench for stonyman_adc_capture: unit 0 at default parameters, unit 1 with
// NUM_PIXELS=4, SCLK_DIV=1, QUIET_CYCLES=1, each fed by a serial ADC model.
module tb_stonyman_adc_capture;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]  rst_d, start_d, frame_d, sdo_d;
  logic [1:0]  done_s, valid_s, busy_s, csn_s, sclk_s, ovf_s;
  logic [11:0] data_s [2];
  logic [13:0] addr_s [2];
  logic [15:0] adc_word [2];
  int          adc_t [2];

  int n_checks = 0;
  int n_pass   = 0;

  stonyman_adc_capture_if ifa ();
  stonyman_adc_capture_if ifb ();

  stonyman_adc_capture u_def (
    .clk   (clk),
    .reset (rst_d[0]),
    .bus   (ifa)
  );

  stonyman_adc_capture #(.SCLK_DIV(1), .QUIET_CYCLES(1), .NUM_PIXELS(4)) u_small (
    .clk   (clk),
    .reset (rst_d[1]),
    .bus   (ifb)
  );

  assign ifa.adc_capture_start   = start_d[0];
  assign ifa.frame_capture_start = frame_d[0];
  assign ifa.adc_sdo             = sdo_d[0];
  assign ifb.adc_capture_start   = start_d[1];
  assign ifb.frame_capture_start = frame_d[1];
  assign ifb.adc_sdo             = sdo_d[1];

  assign done_s  = {ifb.adc_capture_done, ifa.adc_capture_done};
  assign valid_s = {ifb.pixel_valid, ifa.pixel_valid};
  assign busy_s  = {ifb.busy, ifa.busy};
  assign csn_s   = {ifb.adc_cs_n, ifa.adc_cs_n};
  assign sclk_s  = {ifb.adc_sclk, ifa.adc_sclk};
  assign ovf_s   = {ifb.overflow, ifa.overflow};
  assign data_s[0] = ifa.pixel_data;
  assign data_s[1] = ifb.pixel_data;
  assign addr_s[0] = ifa.pixel_addr;
  assign addr_s[1] = ifb.pixel_addr;

  function automatic int div_of(input int u);
    return (u == 0) ? 2 : 1;
  endfunction

  // ADC model: the correct bit is present only on the cycle it must be sampled; the inverse otherwise.
  always @(negedge clk) begin
    for (int u = 0; u < 2; u++) begin
      if (csn_s[u]) begin
        adc_t[u] = 0;
        sdo_d[u] = 1'b0;
      end else if (adc_t[u] < 32 * div_of(u)) begin
        if ((adc_t[u] % (2 * div_of(u))) == div_of(u) - 1)
          sdo_d[u] = adc_word[u][15 - adc_t[u] / (2 * div_of(u))];
        else
          sdo_d[u] = ~adc_word[u][15 - adc_t[u] / (2 * div_of(u))];
        adc_t[u] = adc_t[u] + 1;
      end else begin
        sdo_d[u] = 1'b0;
      end
    end
  end

  typedef struct {
    int          done_cyc;
    int          csn_low;
    int          sclk_edges;
    int          busy_low;
    logic        v;
    logic [11:0] d;
    logic [13:0] a;
    logic [13:0] a_next;
    logic        ovf_next;
    logic        done_next;
    logic [11:0] d_idle;
    logic        idle_ok;
  } run_t;

  typedef struct {
    logic [15:0] word;
    logic        frame_before;
    logic [11:0] exp_data;
    logic [13:0] exp_addr;
    logic        exp_valid;
    logic        exp_ovf;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
  endtask

  task automatic frame_pulse(input int u);
    @(negedge clk);
    frame_d[u] = 1'b1;
    @(negedge clk);
    frame_d[u] = 1'b0;
  endtask

  task automatic run_conv(input int u, input logic [15:0] w, input logic frame_at_done, output run_t r);
    logic prev_sclk;
    r = '{default: 0};
    r.done_cyc = -1;
    adc_word[u] = w;
    @(negedge clk);
    start_d[u] = 1'b1;
    prev_sclk = sclk_s[u];
    for (int k = 1; k <= 200 && r.done_cyc < 0; k++) begin
      @(negedge clk);
      start_d[u] = 1'b0;
      if (!csn_s[u]) r.csn_low++;
      if (sclk_s[u] !== prev_sclk) r.sclk_edges++;
      prev_sclk = sclk_s[u];
      if (!busy_s[u]) r.busy_low++;
      if (done_s[u]) begin
        r.done_cyc = k;
        r.v = valid_s[u];
        r.d = data_s[u];
        r.a = addr_s[u];
        frame_d[u] = frame_at_done;
      end
    end
    @(negedge clk);
    frame_d[u] = 1'b0;
    r.a_next    = addr_s[u];
    r.ovf_next  = ovf_s[u];
    r.done_next = done_s[u];
    for (int k = 0; k < 64 && busy_s[u]; k++) @(negedge clk);
    r.idle_ok = !busy_s[u];
    r.d_idle  = data_s[u];
  endtask

  task automatic check_run(input string n, input int u, input run_t r, input logic exp_v,
                           input logic [11:0] exp_d, input logic [13:0] exp_a,
                           input logic [13:0] exp_a_next, input logic exp_ovf);
    check({n, "_done_cycle"}, r.done_cyc, 32 * div_of(u) + 1);
    check({n, "_csn_low_cycles"}, r.csn_low, 32 * div_of(u));
    check({n, "_sclk_edges"}, r.sclk_edges, 32);
    check({n, "_busy_dropped"}, r.busy_low, 0);
    check({n, "_valid"}, r.v, exp_v);
    check({n, "_data"}, r.d, exp_d);
    check({n, "_addr"}, r.a, exp_a);
    check({n, "_addr_next"}, r.a_next, exp_a_next);
    check({n, "_ovf_next"}, r.ovf_next, exp_ovf);
    check({n, "_done_one_cycle"}, r.done_next, 1'b0);
    check({n, "_returns_idle"}, r.idle_ok, 1'b1);
    check({n, "_data_holds"}, r.d_idle, exp_d);
  endtask

  task automatic spacing_probe(input int probe, output int n_done, output int first_done,
                               output logic csn_after);
    adc_word[1] = 16'h0111;
    n_done = 0;
    first_done = -1;
    csn_after = 1'bx;
    @(negedge clk);
    start_d[1] = 1'b1;
    for (int k = 1; k <= 120; k++) begin
      @(negedge clk);
      start_d[1] = (k == probe);
      if (done_s[1]) begin
        n_done++;
        if (first_done < 0) first_done = k;
      end
      if (k == probe + 1) csn_after = csn_s[1];
    end
    for (int k = 0; k < 64 && busy_s[1]; k++) @(negedge clk);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got no completion, expected finish within time limit");
    $fatal(1);
  end

  initial begin
    vec_t        tbl [7];
    run_t        r;
    int          exp_addr, n_done, busy_bad, first_done, valid_cnt;
    logic [15:0] w;
    logic        csn_after;

    tbl[0] = '{16'h0123, 1'b0, 12'h123, 14'd0, 1'b1, 1'b0};
    tbl[1] = '{16'h0FFF, 1'b0, 12'hFFF, 14'd1, 1'b1, 1'b0};
    tbl[2] = '{16'hF000, 1'b0, 12'h000, 14'd2, 1'b1, 1'b0};
    tbl[3] = '{16'h0A5A, 1'b0, 12'hA5A, 14'd3, 1'b1, 1'b0};
    tbl[4] = '{16'h0555, 1'b0, 12'h555, 14'd4, 1'b0, 1'b1};
    tbl[5] = '{16'h0777, 1'b0, 12'h777, 14'd4, 1'b0, 1'b1};
    tbl[6] = '{16'h0321, 1'b1, 12'h321, 14'd0, 1'b1, 1'b0};

    rst_d = 2'b11;
    start_d = '0;
    frame_d = '0;
    adc_word[0] = '0;
    adc_word[1] = '0;
    repeat (3) @(negedge clk);
    for (int u = 0; u < 2; u++) begin
      check($sformatf("reset_csn_u%0d", u), csn_s[u], 1'b1);
      check($sformatf("reset_sclk_u%0d", u), sclk_s[u], 1'b1);
      check($sformatf("reset_busy_u%0d", u), busy_s[u], 1'b0);
      check($sformatf("reset_done_u%0d", u), done_s[u], 1'b0);
      check($sformatf("reset_valid_u%0d", u), valid_s[u], 1'b0);
      check($sformatf("reset_ovf_u%0d", u), ovf_s[u], 1'b0);
      check($sformatf("reset_data_u%0d", u), data_s[u], 12'h000);
      check($sformatf("reset_addr_u%0d", u), addr_s[u], 14'd0);
    end
    @(negedge clk);
    rst_d = 2'b00;
    repeat (2) @(negedge clk);

    // Basic conversion at default parameters.
    run_conv(0, 16'h0ABC, 1'b0, r);
    check_run("basic", 0, r, 1'b1, 12'hABC, 14'd0, 14'd1, 1'b0);
    exp_addr = 1;

    // Extra starts during CONV and during QUIET are dropped.
    adc_word[0] = 16'h0456;
    n_done = 0;
    busy_bad = 0;
    valid_cnt = 0;
    @(negedge clk);
    start_d[0] = 1'b1;
    for (int k = 1; k <= 200; k++) begin
      @(negedge clk);
      start_d[0] = (k == 20 || k == 67);
      if (done_s[0]) n_done++;
      if (valid_s[0]) valid_cnt++;
      if (busy_s[0] !== (k <= 69)) busy_bad++;
    end
    check("ignore_start_done_count", n_done, 1);
    check("ignore_start_write_count", valid_cnt, 1);
    check("ignore_start_busy_profile", busy_bad, 0);
    check("ignore_start_data", data_s[0], 12'h456);
    check("ignore_start_addr", addr_s[0], 14'(exp_addr + 1));
    exp_addr = exp_addr + 1;

    // Random samples and frame restarts against a simple address/data model.
    for (int i = 0; i < 12; i++) begin
      w = 16'($urandom);
      if ($urandom_range(0, 3) == 0) begin
        frame_pulse(0);
        exp_addr = 0;
        check($sformatf("rand%0d_frame_clear", i), addr_s[0], 14'd0);
      end
      run_conv(0, w, 1'b0, r);
      check_run($sformatf("rand%0d", i), 0, r, 1'b1, w[11:0], 14'(exp_addr), 14'(exp_addr + 1), 1'b0);
      exp_addr = exp_addr + 1;
    end

    // Frame restart coincident with the write at address 7.
    frame_pulse(0);
    check("frame7_clear", addr_s[0], 14'd0);
    for (int i = 0; i < 7; i++) begin
      w = 16'($urandom);
      run_conv(0, w, 1'b0, r);
      check($sformatf("frame7_fill%0d_addr", i), r.a, 14'(i));
      check($sformatf("frame7_fill%0d_data", i), r.d, w[11:0]);
    end
    run_conv(0, 16'h0BEE, 1'b1, r);
    check_run("frame7_coincident", 0, r, 1'b1, 12'hBEE, 14'd7, 14'd0, 1'b0);

    // Reset mid-conversion.
    adc_word[0] = 16'h0321;
    @(negedge clk);
    start_d[0] = 1'b1;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      start_d[0] = 1'b0;
    end
    check("midreset_was_converting", csn_s[0], 1'b0);
    rst_d[0] = 1'b1;
    #1;
    check("midreset_csn", csn_s[0], 1'b1);
    check("midreset_sclk", sclk_s[0], 1'b1);
    check("midreset_busy", busy_s[0], 1'b0);
    @(negedge clk);
    rst_d[0] = 1'b0;
    n_done = 0;
    valid_cnt = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (done_s[0]) n_done++;
      if (valid_s[0]) valid_cnt++;
    end
    check("midreset_no_done", n_done, 0);
    check("midreset_no_write", valid_cnt, 0);
    check("midreset_addr_cleared", addr_s[0], 14'd0);
    run_conv(0, 16'h0C3F, 1'b0, r);
    check_run("after_reset", 0, r, 1'b1, 12'hC3F, 14'd0, 14'd1, 1'b0);

    // Small build: fill past NUM_PIXELS, then restart the frame.
    for (int i = 0; i < 7; i++) begin
      if (tbl[i].frame_before) begin
        frame_pulse(1);
        check($sformatf("tbl%0d_frame_ovf_clear", i), ovf_s[1], 1'b0);
        check($sformatf("tbl%0d_frame_addr_clear", i), addr_s[1], 14'd0);
      end
      run_conv(1, tbl[i].word, 1'b0, r);
      check_run($sformatf("tbl%0d", i), 1, r, tbl[i].exp_valid, tbl[i].exp_data, tbl[i].exp_addr,
                tbl[i].exp_valid ? 14'(tbl[i].exp_addr + 14'd1) : tbl[i].exp_addr, tbl[i].exp_ovf);
    end

    // Small build: start-to-start spacing of 35 cycles.
    spacing_probe(34, n_done, first_done, csn_after);
    check("spacing34_first_done", first_done, 33);
    check("spacing34_rejected_csn", csn_after, 1'b1);
    check("spacing34_done_count", n_done, 1);
    spacing_probe(35, n_done, first_done, csn_after);
    check("spacing35_first_done", first_done, 33);
    check("spacing35_accepted_csn", csn_after, 1'b0);
    check("spacing35_done_count", n_done, 2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
